mem_bus_interface: RTL and testbench

Parametrised memory access unit for the single-bus RISC datapath; the successor to the fixed 32-bit MAR/MDR/RAM trio. It holds MAR and MDR and runs a ready/ack handshake with a variable-latency memory instead of a single-cycle RAM. It stalls the control unit via `busy` and reports completion with `done`. A bounded wait counter turns a hung memory into a reported error rather than a deadlock.

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_wait_counter.sv | 33 +++
 rtl/mem_bus_interface.sv | 128 ++++++++++++
 tb/tb_mem_bus_interface.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus interface: FSM states,
// default widths/timeout and the wait-counter width helper.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_ADDR_W  = 9;
  localparam int DEFAULT_TIMEOUT = 15;

  // Enough bits to hold 0..TIMEOUT; never narrower than one bit.
  function automatic int counter_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Counts wait cycles of one memory transaction and flags the last allowed
// cycle; TIMEOUT of 0 means the flag never rises.
module mem_wait_counter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic enable,
  output logic expired
);

  localparam int CW       = counter_width(TIMEOUT);
  localparam int LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] LAST = LAST_INT[CW-1:0];

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/mem_bus_interface.sv
// MAR/MDR holder with a ready/ack handshake to a variable-latency memory,
// stalling the control unit via busy and reporting done/err.
module mem_bus_interface
  import mem_bus_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] mdr_val,
  output logic [ADDR_W-1:0] mar_val,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t state, next_state;

  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              we_q;
  logic              err_q;
  logic              busy_q;
  logic              done_q;

  logic load_mar, load_mdr, capture_rdata;
  logic accept, set_err, count_start, count_en;
  logic expired;

  mem_wait_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_counter (
    .clock  (clock),
    .clear  (clear),
    .start  (count_start),
    .enable (count_en),
    .expired(expired)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    load_mar      = 1'b0;
    load_mdr      = 1'b0;
    capture_rdata = 1'b0;
    accept        = 1'b0;
    set_err       = 1'b0;
    count_start   = 1'b0;
    count_en      = 1'b0;
    case (state)
      IDLE: begin
        load_mar = mar_in;
        load_mdr = mdr_in;
        // Conflicting commands are reported and never reach the memory.
        if (read && write) begin
          set_err = 1'b1;
        end else if (read || write) begin
          accept      = 1'b1;
          count_start = 1'b1;
          next_state  = REQ;
        end
      end
      REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          capture_rdata = ~we_q;
          next_state    = DONE;
        end else if (expired) begin
          set_err    = 1'b1;
          next_state = DONE;
        end else begin
          count_en = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy/done are flopped from next_state so they track the state exactly.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mar    <= '0;
      mdr    <= '0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (load_mar) mar <= bus_in[ADDR_W-1:0];
      if (capture_rdata)  mdr <= mem_rdata;
      else if (load_mdr)  mdr <= bus_in;
      if (accept) we_q <= write;
      if (set_err)     err_q <= 1'b1;
      else if (accept) err_q <= 1'b0;
      busy_q <= (next_state == REQ);
      done_q <= (next_state == DONE);
    end
  end

  assign mar_val   = mar;
  assign mdr_val   = mdr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign mem_we    = we_q;
  assign mem_req   = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed bench for mem_bus_interface with a 4-cycle timeout; each task
// drives one scenario and compares outputs against hand-computed values.
module tb_mem_bus_interface;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 4;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic [DATA_W-1:0] bus_in = '0;
  logic              mar_in = 1'b0;
  logic              mdr_in = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [DATA_W-1:0] mdr_val;
  logic [ADDR_W-1:0] mar_val;
  logic              busy, done, err, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  mem_bus_interface #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .bus_in   (bus_in),
    .mar_in   (mar_in),
    .mdr_in   (mdr_in),
    .read     (read),
    .write    (write),
    .mdr_val  (mdr_val),
    .mar_val  (mar_val),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    total++;
    if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b want=00000", {busy, done, err, mem_req, mem_we});
    end
    total++;
    if (mar_val !== '0 || mdr_val !== '0) begin
      bad++; $display("[TB] FAIL reset_regs mar=%h mdr=%h want=0", mar_val, mdr_val);
    end
    clear = 1'b0;
    step();
  endtask

  task automatic test_zero_wait_read();
    bus_in = 32'h0000_0012; mar_in = 1'b1;
    step();
    mar_in = 1'b0; read = 1'b1;
    step();
    total++;
    if ({mem_req, busy, mem_we, done} !== 4'b1100 || mem_addr !== 9'h012) begin
      bad++; $display("[TB] FAIL zw_req req/busy/we/done=%b addr=%h want=1100 012", {mem_req, busy, mem_we, done}, mem_addr);
    end
    read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    total++;
    if ({done, busy, mem_req} !== 3'b100 || mdr_val !== 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL zw_done done/busy/req=%b mdr=%h want=100 deadbeef", {done, busy, mem_req}, mdr_val);
    end
    mem_ack = 1'b0;
    step();
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("[TB] FAIL zw_idle done/busy=%b want=00", {done, busy});
    end
  endtask

  task automatic test_write_waits();
    int req_cycles = 0, we_cycles = 0, done_cycles = 0, wdata_bad = 0;
    bus_in = 32'h1234_5678; mdr_in = 1'b1;
    step();
    mdr_in = 1'b0; bus_in = 32'h0000_00FF; mar_in = 1'b1;
    step();
    mar_in = 1'b0; write = 1'b1;
    step();
    write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) begin
        req_cycles++;
        if (mem_we) we_cycles++;
        if (mem_wdata !== 32'h1234_5678 || mem_addr !== 9'h0FF) wdata_bad++;
      end
      if (done) done_cycles++;
      mem_ack = mem_req && (req_cycles == 4);
      step();
    end
    mem_ack = 1'b0;
    total++;
    if (req_cycles != 4 || we_cycles != 4) begin
      bad++; $display("[TB] FAIL wr_req_cycles req=%0d we=%0d want=4 4", req_cycles, we_cycles);
    end
    total++;
    if (done_cycles != 1 || wdata_bad != 0 || err !== 1'b0) begin
      bad++; $display("[TB] FAIL wr_result done=%0d wdata_bad=%0d err=%b want=1 0 0", done_cycles, wdata_bad, err);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0, done_cycles = 0, done_err = 0;
    read = 1'b1;
    step();
    read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) req_cycles++;
      if (done) begin
        done_cycles++;
        if (err) done_err++;
      end
      step();
    end
    total++;
    if (req_cycles != TIMEOUT || done_cycles != 1 || done_err != 1) begin
      bad++; $display("[TB] FAIL to_cycles req=%0d done=%0d done_err=%0d want=4 1 1", req_cycles, done_cycles, done_err);
    end
    total++;
    if (mdr_val !== 32'h1234_5678 || err !== 1'b1) begin
      bad++; $display("[TB] FAIL to_hold mdr=%h err=%b want=12345678 1", mdr_val, err);
    end
    read = 1'b1;
    step();
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL to_err_clear err=%b busy=%b want=0 1", err, busy);
    end
    read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    step();
    mem_ack = 1'b0;
    step();
    total++;
    if (mdr_val !== 32'hCAFE_0001) begin
      bad++; $display("[TB] FAIL to_next_read mdr=%h want=cafe0001", mdr_val);
    end
  endtask

  task automatic test_both();
    read = 1'b1; write = 1'b1;
    step();
    total++;
    if ({err, mem_req, busy} !== 3'b100) begin
      bad++; $display("[TB] FAIL both_first err/req/busy=%b want=100", {err, mem_req, busy});
    end
    step();
    total++;
    if ({mem_req, busy, done} !== 3'b000) begin
      bad++; $display("[TB] FAIL both_held req/busy/done=%b want=000", {mem_req, busy, done});
    end
    read = 1'b0; write = 1'b0;
    step();
    total++;
    if (err !== 1'b1) begin
      bad++; $display("[TB] FAIL both_sticky err=%b want=1", err);
    end
  endtask

  task automatic test_back_to_back();
    read = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    total++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_first busy=%b err=%b want=1 0", busy, err);
    end
    step();
    total++;
    if (done !== 1'b1 || mdr_val !== 32'h0BAD_F00D) begin
      bad++; $display("[TB] FAIL b2b_done done=%b mdr=%h want=1 0badf00d", done, mdr_val);
    end
    step();
    total++;
    if ({busy, done, mem_req} !== 3'b000) begin
      bad++; $display("[TB] FAIL b2b_gap busy/done/req=%b want=000", {busy, done, mem_req});
    end
    step();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_restart busy=%b want=1", busy);
    end
    read = 1'b0; mem_rdata = 32'h0000_0042;
    step();
    mem_ack = 1'b0;
    total++;
    if (done !== 1'b1 || mdr_val !== 32'h0000_0042) begin
      bad++; $display("[TB] FAIL b2b_second done=%b mdr=%h want=1 00000042", done, mdr_val);
    end
    step();
  endtask

  task automatic test_freeze();
    bus_in = 32'h0000_0055; mar_in = 1'b1;
    step();
    bus_in = 32'hA5A5_0F0F; mar_in = 1'b0; mdr_in = 1'b1;
    step();
    mdr_in = 1'b0; write = 1'b1;
    step();
    write = 1'b0; bus_in = 32'hFFFF_FFFF; mar_in = 1'b1; mdr_in = 1'b1;
    step();
    total++;
    if (mem_addr !== 9'h055 || mem_wdata !== 32'hA5A5_0F0F || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL frz_req addr=%h wdata=%h busy=%b want=055 a5a50f0f 1", mem_addr, mem_wdata, busy);
    end
    mem_ack = 1'b1;
    step();
    total++;
    if (mem_addr !== 9'h055 || mem_wdata !== 32'hA5A5_0F0F || done !== 1'b1) begin
      bad++; $display("[TB] FAIL frz_done addr=%h wdata=%h done=%b want=055 a5a50f0f 1", mem_addr, mem_wdata, done);
    end
    mar_in = 1'b0; mdr_in = 1'b0; mem_ack = 1'b0;
    step();
    total++;
    if (mem_addr !== 9'h055 || mem_wdata !== 32'hA5A5_0F0F) begin
      bad++; $display("[TB] FAIL frz_after addr=%h wdata=%h want=055 a5a50f0f", mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_ack = 1'b0;
    total++;
    if ({busy, done, mem_req} !== 3'b000 || mdr_val !== 32'hA5A5_0F0F) begin
      bad++; $display("[TB] FAIL frz_late_ack busy/done/req=%b mdr=%h want=000 a5a50f0f", {busy, done, mem_req}, mdr_val);
    end
  endtask

  task automatic test_clear_mid();
    bus_in = 32'h0000_01AB; mar_in = 1'b1;
    step();
    bus_in = 32'h0000_0077; mar_in = 1'b0; mdr_in = 1'b1;
    step();
    mdr_in = 1'b0; read = 1'b1;
    step();
    read = 1'b0;
    total++;
    if (mem_req !== 1'b1 || mar_val !== 9'h1AB) begin
      bad++; $display("[TB] FAIL clr_pre req=%b mar=%h want=1 1ab", mem_req, mar_val);
    end
    #2 clear = 1'b1;
    #1;
    total++;
    if ({mem_req, busy, done, err} !== 4'b0000 || mar_val !== '0 || mdr_val !== '0) begin
      bad++; $display("[TB] FAIL clr_async req/busy/done/err=%b mar=%h mdr=%h want=0000 0 0", {mem_req, busy, done, err}, mar_val, mdr_val);
    end
    #1 clear = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
    step();
    mem_ack = 1'b0;
    total++;
    if ({busy, done, mem_req} !== 3'b000 || mdr_val !== '0) begin
      bad++; $display("[TB] FAIL clr_post_ack busy/done/req=%b mdr=%h want=000 0", {busy, done, mem_req}, mdr_val);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_waits();
    test_timeout();
    test_both();
    test_back_to_back();
    test_freeze();
    test_clear_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
